// File: rtl/btb_assoc.sv
// btb_assoc: two-way set-associative branch target buffer.
//
// Looked up every cycle with the fetch PC. The hit, the prediction and the
// target are registered, so they appear one cycle after the PC.
// Updated at commit with the resolved outcome of a branch.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   PC             fetch PC for lookup
//   validRead      registered lookup hit
//   predictTaken   registered MSB of the hit entry's counter (0 on miss)
//   targetAddress  registered target of the hit entry (0 on miss)
//   writeBTB       commit update strobe
//   oldPC          PC of the committing branch
//   resolvedTarget resolved target of the committing branch
//   takenBranch    resolved direction of the committing branch
module btb_assoc #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  output logic              validRead,
  output logic              predictTaken,
  output logic [ADDR_W-1:0] targetAddress,
  input  logic              writeBTB,
  input  logic [ADDR_W-1:0] oldPC,
  input  logic [ADDR_W-1:0] resolvedTarget,
  input  logic              takenBranch
);

  localparam int SETS = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  // Weakly taken: only the MSB set.
  localparam logic [CTR_W-1:0] CTR_INIT = (CTR_MAX >> 1) + 1'b1;

  logic              valid_q [2][SETS];
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [ADDR_W-1:0] tgt_q   [2][SETS];
  logic [CTR_W-1:0]  ctr_q   [2][SETS];
  logic              lru_q   [SETS];  // way to evict next

  // Lookup side
  logic [INDEX_W-1:0] rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_hit0, rd_hit1, rd_hit, rd_way;

  assign rd_idx  = PC[INDEX_W-1:0];
  assign rd_tag  = PC[INDEX_W+TAG_W-1:INDEX_W];
  assign rd_hit0 = valid_q[0][rd_idx] && (tag_q[0][rd_idx] == rd_tag);
  assign rd_hit1 = valid_q[1][rd_idx] && (tag_q[1][rd_idx] == rd_tag);
  assign rd_hit  = rd_hit0 || rd_hit1;
  assign rd_way  = rd_hit1;

  // Update side, evaluated against pre-edge state
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic               wr_hit0, wr_hit1, wr_hit, wr_way, victim;
  logic [CTR_W-1:0]   wr_ctr;

  assign wr_idx  = oldPC[INDEX_W-1:0];
  assign wr_tag  = oldPC[INDEX_W+TAG_W-1:INDEX_W];
  assign wr_hit0 = valid_q[0][wr_idx] && (tag_q[0][wr_idx] == wr_tag);
  assign wr_hit1 = valid_q[1][wr_idx] && (tag_q[1][wr_idx] == wr_tag);
  assign wr_hit  = wr_hit0 || wr_hit1;
  assign wr_way  = wr_hit1;
  assign wr_ctr  = ctr_q[wr_way][wr_idx];

  // Fill invalid ways first, otherwise evict the LRU way.
  assign victim = !valid_q[0][wr_idx] ? 1'b0 :
                  !valid_q[1][wr_idx] ? 1'b1 : lru_q[wr_idx];

  // Valid bits, LRU bits and the registered lookup outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
        lru_q[s]      <= 1'b0;
      end
      validRead     <= 1'b0;
      predictTaken  <= 1'b0;
      targetAddress <= '0;
    end else begin
      validRead     <= rd_hit;
      predictTaken  <= rd_hit ? ctr_q[rd_way][rd_idx][CTR_W-1] : 1'b0;
      targetAddress <= rd_hit ? tgt_q[rd_way][rd_idx] : '0;
      if (rd_hit)
        lru_q[rd_idx] <= ~rd_way;
      // Placed after the lookup LRU write so an update to the same set wins.
      if (writeBTB) begin
        if (wr_hit) begin
          lru_q[wr_idx] <= ~wr_way;
          if (!takenBranch && (wr_ctr == '0))
            valid_q[wr_way][wr_idx] <= 1'b0;
        end else if (takenBranch) begin
          valid_q[victim][wr_idx] <= 1'b1;
          lru_q[wr_idx]           <= ~victim;
        end
      end
    end
  end

  // Payload arrays carry no reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (writeBTB && !reset) begin
      if (wr_hit) begin
        if (takenBranch) begin
          ctr_q[wr_way][wr_idx] <= (wr_ctr == CTR_MAX) ? CTR_MAX : wr_ctr + 1'b1;
          tgt_q[wr_way][wr_idx] <= resolvedTarget;
        end else if (wr_ctr != '0) begin
          ctr_q[wr_way][wr_idx] <= wr_ctr - 1'b1;
        end
      end else if (takenBranch) begin
        tag_q[victim][wr_idx] <= wr_tag;
        tgt_q[victim][wr_idx] <= resolvedTarget;
        ctr_q[victim][wr_idx] <= CTR_INIT;
      end
    end
  end

  // PC bits above index+tag deliberately alias.
  generate
    if (INDEX_W + TAG_W < ADDR_W) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{PC[ADDR_W-1:INDEX_W+TAG_W], oldPC[ADDR_W-1:INDEX_W+TAG_W]};
    end
  endgenerate

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: scoreboard bench for btb_assoc with default parameters.
module tb_btb_assoc;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] PC;
  logic              validRead;
  logic              predictTaken;
  logic [ADDR_W-1:0] targetAddress;
  logic              writeBTB;
  logic [ADDR_W-1:0] oldPC;
  logic [ADDR_W-1:0] resolvedTarget;
  logic              takenBranch;

  typedef struct {
    logic        v;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  btb_assoc #(.ADDR_W(32), .INDEX_W(4), .TAG_W(8), .CTR_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .PC             (PC),
    .validRead      (validRead),
    .predictTaken   (predictTaken),
    .targetAddress  (targetAddress),
    .writeBTB       (writeBTB),
    .oldPC          (oldPC),
    .resolvedTarget (resolvedTarget),
    .takenBranch    (takenBranch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle at the falling edge, push the expected lookup result,
  // then compare it just after the rising edge that registers it.
  task automatic step(input string tag, input logic [31:0] pc,
                      input logic wr, input logic [31:0] opc, input logic [31:0] rt,
                      input logic tk, input logic ev, input logic ept, input logic [31:0] etgt);
    exp_t e;
    exp_t o;
    @(negedge clk);
    PC = pc; writeBTB = wr; oldPC = opc; resolvedTarget = rt; takenBranch = tk;
    e.v = ev; e.pt = ept; e.tgt = etgt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      chk({tag, ".valid"},  {31'd0, validRead},    {31'd0, o.v});
      chk({tag, ".pred"},   {31'd0, predictTaken}, {31'd0, o.pt});
      chk({tag, ".target"}, targetAddress,         o.tgt);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic ev, input logic ept, input logic [31:0] etgt);
    step(tag, pc, 1'b0, 32'd0, 32'd0, 1'b0, ev, ept, etgt);
  endtask

  initial begin
    reset = 1'b1; PC = 32'd1; writeBTB = 1'b0; oldPC = '0;
    resolvedTarget = '0; takenBranch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid",  {31'd0, validRead},    32'd0);
    chk("rst.target", targetAddress,         32'd0);
    @(negedge clk);
    reset = 1'b0;

    look("pwr", 1, 0, 0, 0);

    // Allocate while looking up the same PC: old data first.
    step("alloc_same", 1, 1, 1, 30, 1, 0, 0, 0);
    look("alloc_hit", 1, 1, 1, 30);

    // Set conflict.
    step("alloc17", 17, 1, 17, 50, 1, 0, 0, 0);
    look("hit17", 17, 1, 1, 50);
    look("hit1", 1, 1, 1, 30);
    step("alloc33", 1, 1, 33, 70, 1, 1, 1, 30);
    look("evict17", 17, 0, 0, 0);
    look("hit1b", 1, 1, 1, 30);
    look("hit33", 33, 1, 1, 70);

    // Hysteresis on PC=33 (counter 2).
    step("nt33a", 0, 1, 33, 0, 0, 0, 0, 0);
    step("nt33b", 33, 1, 33, 0, 0, 1, 0, 70);
    look("ctr0_33", 33, 1, 0, 70);
    step("nt33c", 0, 1, 33, 0, 0, 0, 0, 0);
    look("gone33", 33, 0, 0, 0);

    // Saturation and target change on PC=1 (counter 2).
    step("tk1a", 0, 1, 1, 30, 1, 0, 0, 0);
    step("tk1b", 0, 1, 1, 30, 1, 0, 0, 0);
    step("tk1c", 0, 1, 1, 90, 1, 0, 0, 0);
    look("newtgt", 1, 1, 1, 90);
    step("nt1a", 0, 1, 1, 0, 0, 0, 0, 0);
    look("sat3to2", 1, 1, 1, 90);
    step("nt1b", 0, 1, 1, 0, 0, 0, 0, 0);
    look("ctr1", 1, 1, 0, 90);

    // Miss not-taken changes nothing.
    step("miss_nt", 0, 1, 49, 77, 0, 0, 0, 0);
    look("no49", 49, 0, 0, 0);
    look("still1", 1, 1, 0, 90);

    // Same-entry collision returns old contents.
    step("coll", 1, 1, 1, 100, 1, 1, 0, 90);
    look("coll_new", 1, 1, 1, 100);

    // Asynchronous reset in the middle of an allocate.
    @(negedge clk);
    PC = 1; writeBTB = 1; oldPC = 5; resolvedTarget = 55; takenBranch = 1;
    #2;
    reset = 1'b1;
    #1;
    chk("async.valid",  {31'd0, validRead},    32'd0);
    chk("async.pred",   {31'd0, predictTaken}, 32'd0);
    chk("async.target", targetAddress,         32'd0);
    @(negedge clk);
    writeBTB = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    look("post5", 5, 0, 0, 0);
    look("post1", 1, 0, 0, 0);
    look("post17", 17, 0, 0, 0);
    look("post33", 33, 0, 0, 0);

    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
